// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl
// Receives one 8N1-style serial frame at a time and hands the byte to a
// downstream consumer. The line is synchronised first. A start bit is only
// accepted if it is still low at mid-bit. Data is sampled once per bit period
// and shifted in LSB-first, and then the stop bit is checked.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   rx_in      asynchronous serial line, idle high
//   rx_data    last good received byte, bit 0 = first data bit on the wire
//   rx_valid   one-cycle pulse, rx_data was updated this cycle
//   frame_err  one-cycle pulse, stop bit was sampled low
//   busy       high whenever the receiver is not idle
//   start_det  one-cycle pulse when a start bit is qualified at mid-bit

module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 busy,
    output logic                 start_det
);

    localparam int HALF_BIT = (CLKS_PER_BIT - 1) / 2;
    localparam int IDX_W    = $clog2(DATA_BITS);

    localparam logic [15:0]      HALF_CNT = 16'(HALF_BIT);
    localparam logic [15:0]      LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } state_t;

    state_t               state_q,     state_d;
    logic                 sync1_q,     sync1_d;
    logic                 sync2_q,     sync2_d;
    logic [15:0]          cnt_q,       cnt_d;
    logic [IDX_W-1:0]     bit_idx_q,   bit_idx_d;
    logic [DATA_BITS-1:0] shift_q,     shift_d;
    logic [DATA_BITS-1:0] rx_data_q,   rx_data_d;
    logic                 rx_valid_q,  rx_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 start_det_q, start_det_d;

    logic rx_s;
    assign rx_s = sync2_q;

    // State register and all datapath flops. The synchroniser flops reset to
    // 1 so that leaving reset does not look like a falling start edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            start_det_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            start_det_q <= start_det_d;
        end
    end

    // Next-state and datapath logic. The baud counter free-runs inside a
    // state and is cleared on every transition. It is also cleared at each
    // data sample so that the next bit is timed from that sample.
    always_comb begin
        state_d     = state_q;
        sync1_d     = rx_in;
        sync2_d     = sync1_q;
        cnt_d       = cnt_q + 16'd1;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        start_det_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d     = '0;
                bit_idx_d = '0;
                if (!rx_s) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // A start bit that is high again at mid-bit is treated as a
                // glitch and dropped without any pulse.
                if (cnt_q == HALF_CNT) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        start_det_d = 1'b1;
                        bit_idx_d   = '0;
                        state_d     = ST_DATA;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DATA: begin
                // Each new bit enters at the MSB. After DATA_BITS shifts, the
                // first bit on the wire has reached bit 0.
                if (cnt_q == LAST_CNT) begin
                    cnt_d     = '0;
                    shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == LAST_IDX) begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        rx_data_d  = shift_q;
                        rx_valid_d = 1'b1;
                        state_d    = ST_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = ST_BREAK;
                    end
                end
            end
            ST_BREAK: begin
                // If the line is held low after a bad stop bit, it must go
                // high before another start edge is accepted.
                if (rx_s) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic. The pulses come straight from flops, and busy is decoded
    // from the state register.
    always_comb begin
        rx_data   = rx_data_q;
        rx_valid  = rx_valid_q;
        frame_err = frame_err_q;
        start_det = start_det_q;
        busy      = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl
// Directed bench for uart_rx_ctrl with 8 clocks per bit. A negedge monitor
// tallies output pulses, busy cycles and the bytes delivered. Each scenario
// snapshots those tallies and compares the deltas with hand-computed values.

module tb_uart_rx_ctrl;

    localparam int CPB = 8;

    logic       clk;
    logic       rst;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       busy;
    logic       start_det;

    int num_compared   = 0;
    int num_mismatched = 0;

    int valid_cnt   = 0;
    int err_cnt     = 0;
    int sdet_cnt    = 0;
    int busy_cycles = 0;
    int overlap_cnt = 0;
    logic [7:0] got_q[$];

    uart_rx_ctrl #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_in    (rx_in),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .frame_err(frame_err),
        .busy     (busy),
        .start_det(start_det)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sample DUT outputs mid-cycle and keep running tallies. Every received
    // byte is queued so that scenarios can check ordering.
    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt = valid_cnt + 1;
            got_q.push_back(rx_data);
        end
        if (frame_err)             err_cnt     = err_cnt + 1;
        if (start_det)             sdet_cnt    = sdet_cnt + 1;
        if (busy)                  busy_cycles = busy_cycles + 1;
        if (rx_valid && frame_err) overlap_cnt = overlap_cnt + 1;
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_compared = num_compared + 1;
        if (observed !== expected) begin
            num_mismatched = num_mismatched + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Hold the line at one level for n clocks, changing it on a negedge
    task automatic holdBit(input logic v, input int n);
        rx_in = v;
        repeat (n) @(negedge clk);
    endtask

    // One full frame: start bit, eight data bits LSB-first, then the stop bit
    task automatic applyStimulus(input logic [7:0] data, input logic stop_bit);
        holdBit(1'b0, CPB);
        for (int i = 0; i < 8; i++) holdBit(data[i], CPB);
        holdBit(stop_bit, CPB);
    endtask

    int v0, e0, s0, b0, q0;

    task automatic snap();
        v0 = valid_cnt;
        e0 = err_cnt;
        s0 = sdet_cnt;
        b0 = busy_cycles;
        q0 = got_q.size();
    endtask

    // Scenario sequencing
    initial begin
        logic [7:0] sweep_byte;
        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_rx_data",   32'(rx_data),   32'h0);
        checkOutput("reset_rx_valid",  32'(rx_valid),  32'h0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
        checkOutput("reset_busy",      32'(busy),      32'h0);
        checkOutput("reset_start_det", 32'(start_det), 32'h0);
        rst = 1'b0;
        holdBit(1'b1, 10);

        // Single frame 0xA5
        snap();
        applyStimulus(8'hA5, 1'b1);
        holdBit(1'b1, 12);
        checkOutput("a5_start_det", 32'(sdet_cnt - s0),  32'd1);
        checkOutput("a5_valid",     32'(valid_cnt - v0), 32'd1);
        checkOutput("a5_data",      32'(got_q[q0]),      32'hA5);
        checkOutput("a5_frame_err", 32'(err_cnt - e0),   32'd0);
        checkOutput("a5_busy_low",  32'(busy),           32'h0);

        // Back-to-back 0x00 then 0xFF with no idle gap
        snap();
        applyStimulus(8'h00, 1'b1);
        applyStimulus(8'hFF, 1'b1);
        holdBit(1'b1, 12);
        checkOutput("b2b_valid",     32'(valid_cnt - v0), 32'd2);
        checkOutput("b2b_first",     32'(got_q[q0]),      32'h00);
        checkOutput("b2b_second",    32'(got_q[q0+1]),    32'hFF);
        checkOutput("b2b_frame_err", 32'(err_cnt - e0),   32'd0);

        // A 2-cycle glitch is busy for START cycles 0..HALF_BIT, then dropped
        snap();
        holdBit(1'b0, 2);
        holdBit(1'b1, 20);
        checkOutput("glitch_start_det", 32'(sdet_cnt - s0),    32'd0);
        checkOutput("glitch_valid",     32'(valid_cnt - v0),   32'd0);
        checkOutput("glitch_busy",      32'(busy_cycles - b0), 32'd4);

        // Bad stop bit followed by a held-low line
        snap();
        applyStimulus(8'h3C, 1'b0);
        holdBit(1'b0, 20);
        checkOutput("ferr_busy_in_break", 32'(busy), 32'h1);
        holdBit(1'b1, 12);
        checkOutput("ferr_pulse",     32'(err_cnt - e0),   32'd1);
        checkOutput("ferr_no_valid",  32'(valid_cnt - v0), 32'd0);
        checkOutput("ferr_start_det", 32'(sdet_cnt - s0),  32'd1);
        checkOutput("ferr_keep_data", 32'(rx_data),        32'hFF);
        checkOutput("ferr_busy_low",  32'(busy),           32'h0);
        snap();
        applyStimulus(8'h42, 1'b1);
        holdBit(1'b1, 12);
        checkOutput("recover_valid", 32'(valid_cnt - v0), 32'd1);
        checkOutput("recover_data",  32'(got_q[q0]),      32'h42);

        // Reset in the middle of data bit 4 of 0x5A
        snap();
        holdBit(1'b0, CPB);
        holdBit(1'b0, CPB);
        holdBit(1'b1, CPB);
        holdBit(1'b0, CPB);
        holdBit(1'b1, CPB);
        holdBit(1'b1, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_data_cleared", 32'(rx_data), 32'h0);
        checkOutput("abort_busy_cleared", 32'(busy),    32'h0);
        holdBit(1'b1, 30);
        checkOutput("abort_no_valid", 32'(valid_cnt - v0), 32'd0);
        checkOutput("abort_no_err",   32'(err_cnt - e0),   32'd0);
        snap();
        applyStimulus(8'h81, 1'b1);
        holdBit(1'b1, 12);
        checkOutput("after_abort_valid", 32'(valid_cnt - v0), 32'd1);
        checkOutput("after_abort_data",  32'(got_q[q0]),      32'h81);

        // All byte values with a random idle gap of 0..20 clocks
        snap();
        for (int v = 0; v < 256; v++) begin
            sweep_byte = 8'(v);
            applyStimulus(sweep_byte, 1'b1);
            holdBit(1'b1, int'($urandom_range(0, 20)));
        end
        holdBit(1'b1, 20);
        checkOutput("sweep_count", 32'(valid_cnt - v0), 32'd256);
        checkOutput("sweep_err",   32'(err_cnt - e0),   32'd0);
        for (int v = 0; v < 256; v++) begin
            checkOutput($sformatf("sweep_byte_%0d", v), 32'(got_q[q0+v]), 32'(v));
        end

        checkOutput("valid_err_overlap", 32'(overlap_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", num_compared, num_mismatched);
        $finish;
    end

endmodule
